// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*SIZE-bit dividend by SIZE-bit divisor,
// one quotient bit per clock, MSB first, with a divide-by-zero shortcut.
module seq_divider #(
    parameter int SIZE = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2*SIZE-1:0]   a,
    input  logic [SIZE-1:0]     b,
    output logic [2*SIZE-1:0]   q,
    output logic [SIZE-1:0]     r,
    output logic                busy,
    output logic                done,
    output logic                dbz
);
    localparam int CNT_W = $clog2(2*SIZE+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div0_q, div0_d;
    logic [2*SIZE-1:0]  q_q, q_d;
    logic [SIZE-1:0]    r_q, r_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [2*SIZE-1:0]  shreg_q, shreg_d;
    logic [SIZE-1:0]    div_q, div_d;
    logic [SIZE-1:0]    rem_q, rem_d;
    logic [SIZE:0]      rem_shift;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div0_d    = div0_q;
        q_d       = q_q;
        r_d       = r_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        shreg_d   = shreg_q;
        div_d     = div_q;
        rem_d     = rem_q;
        rem_shift = {rem_q, shreg_q[2*SIZE-1]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = a;
                    div_d   = b;
                    rem_d   = '0;
                    if (b == '0) begin
                        div0_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        div0_d  = 1'b0;
                        cnt_d   = CNT_W'(2*SIZE);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Stored remainder is always < divisor, so the difference fits in SIZE bits.
                if (rem_shift >= {1'b0, div_q}) begin
                    rem_d   = rem_shift[SIZE-1:0] - div_q;
                    shreg_d = {shreg_q[2*SIZE-2:0], 1'b1};
                end else begin
                    rem_d   = rem_shift[SIZE-1:0];
                    shreg_d = {shreg_q[2*SIZE-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                dbz_d   = div0_q;
                q_d     = div0_q ? '1 : shreg_q;
                r_d     = div0_q ? shreg_q[SIZE-1:0] : rem_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div0_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div0_q  <= div0_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        div_q   <= div_d;
        rem_q   <= rem_d;
    end

    assign q    = q_q;
    assign r    = r_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign dbz  = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (SIZE=8) with hand-computed expected results.
module tb_seq_divider;
    localparam int SIZE = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic [2*SIZE-1:0] a;
    logic [SIZE-1:0]   b;
    logic [2*SIZE-1:0] q;
    logic [SIZE-1:0]   r;
    logic              busy;
    logic              done;
    logic              dbz;

    int n_assert = 0;
    int n_fail   = 0;

    seq_divider #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents a request for exactly one edge; returns just after the accepting edge.
    task automatic do_start(input logic [2*SIZE-1:0] av, input logic [SIZE-1:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int ndone;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) tick();
        chk("reset_q", 32'(q), 0);
        chk("reset_r", 32'(r), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_dbz", 32'(dbz), 0);

        // Start on the very first edge with reset low.
        reset = 1'b0;
        do_start(16'd100, 8'd7);
        chk("basic_busy", 32'(busy), 1);
        wait_done(n);
        chk("basic_latency", 32'(n), 17);
        chk("basic_q", 32'(q), 14);
        chk("basic_r", 32'(r), 2);
        chk("basic_dbz", 32'(dbz), 0);
        tick();
        chk("basic_done_pulse", 32'(done), 0);
        chk("basic_idle", 32'(busy), 0);
        chk("basic_hold_q", 32'(q), 14);

        do_start(16'd65025, 8'd255);
        wait_done(n);
        chk("rt1_latency", 32'(n), 17);
        chk("rt1_q", 32'(q), 255);
        chk("rt1_r", 32'(r), 0);
        tick();

        do_start(16'd65535, 8'd1);
        wait_done(n);
        chk("rt2_q", 32'(q), 65535);
        chk("rt2_r", 32'(r), 0);
        tick();

        do_start(16'h1234, 8'd0);
        wait_done(n);
        chk("dbz_latency", 32'(n), 1);
        chk("dbz_q", 32'(q), 32'hFFFF);
        chk("dbz_r", 32'(r), 32'h34);
        chk("dbz_flag", 32'(dbz), 1);
        tick();
        chk("dbz_hold", 32'(dbz), 1);

        do_start(16'd20, 8'd3);
        wait_done(n);
        chk("dbz_clear_q", 32'(q), 6);
        chk("dbz_clear_r", 32'(r), 2);
        chk("dbz_clear_flag", 32'(dbz), 0);
        tick();

        // A second request mid-run must be ignored.
        do_start(16'd50, 8'd5);
        n = 0;
        ndone = 0;
        while (n < 17) begin
            if (n == 4) begin
                a     = 16'd9;
                b     = 8'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
            if (done === 1'b1) ndone++;
            if (n < 17) chk("swb_busy", 32'(busy), 1);
        end
        chk("swb_done_at_17", 32'(done), 1);
        chk("swb_q", 32'(q), 10);
        chk("swb_r", 32'(r), 0);
        repeat (3) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("swb_single_done", 32'(ndone), 1);

        // Reset in the middle of a run aborts it silently.
        do_start(16'd200, 8'd3);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_q", 32'(q), 0);
        chk("abort_r", 32'(r), 0);
        chk("abort_done", 32'(done), 0);
        ndone = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 0);
        do_start(16'd9, 8'd2);
        wait_done(n);
        chk("abort_restart_latency", 32'(n), 17);
        chk("abort_restart_q", 32'(q), 4);
        chk("abort_restart_r", 32'(r), 1);
        tick();

        // Back-to-back: second request in the cycle after the done pulse.
        do_start(16'd1000, 8'd9);
        wait_done(n);
        chk("b2b1_latency", 32'(n), 17);
        chk("b2b1_q", 32'(q), 111);
        chk("b2b1_r", 32'(r), 1);
        tick();
        do_start(16'd60001, 8'd250);
        chk("b2b2_hold_q", 32'(q), 111);
        wait_done(n);
        chk("b2b2_latency", 32'(n), 17);
        chk("b2b2_q", 32'(q), 240);
        chk("b2b2_r", 32'(r), 1);
        chk("b2b2_dbz", 32'(dbz), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter SIZE, default 8; divisor width in bits; dividend and quotient are 2*SIZE bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port a  input  2*SIZE  unsigned dividend; sampled when start is accepted.
REQ-006 SHALL have port b  input  SIZE  unsigned divisor; sampled when start is accepted.
REQ-007 SHALL have port q  output  2*SIZE  unsigned quotient, registered.
REQ-008 SHALL have port r  output  SIZE  unsigned remainder, registered.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; q, r and dbz are valid in that cycle.
REQ-011 SHALL have port dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1 and b!=0:
- capture a and b;
- clear the partial remainder;
- load iteration counter = 2*SIZE;
- go to RUN.
REQ-014 SHALL, in RUN, perform one restoring-division step per cycle, MSB first:
- shift the next dividend bit into the partial remainder (SIZE+1 bits wide);
- if partial remainder >= divisor, subtract the divisor and set the quotient bit to 1; otherwise set it to 0;
- decrement the counter.
REQ-015 SHALL go from RUN to DONE after exactly 2*SIZE RUN cycles.
REQ-016 SHALL, in DONE:
- drive done=1 for exactly one cycle;
- update q and r with the final result;
- go to IDLE on the next cycle.
REQ-017 SHALL assert done on the (2*SIZE+1)th rising edge after the edge that accepted start (17 cycles for SIZE=8).
REQ-018 SHALL, in IDLE with start=1 and b==0:
- go directly to DONE on the next cycle with q = all ones, r = a[SIZE-1:0], dbz=1.
REQ-019 SHALL clear dbz to 0 at completion of every division with b!=0.
REQ-020 SHALL ignore start while busy=1; a, b and start changes during RUN/DONE SHALL NOT affect the result in progress.
REQ-021 SHALL hold q, r and dbz stable from the done pulse until the next done pulse.
REQ-022 SHALL accept a start asserted in the cycle immediately after the done pulse (back-to-back operation).
REQ-023 SHALL satisfy a == q*b + r and r < b for every b!=0 (the inverse of the team's SIZE-by-SIZE multiplier: a = x*y, b = y gives q = x, r = 0).
REQ-024 SHALL treat all arithmetic as unsigned, with no truncation of intermediate partial remainders.

Reset
REQ-025 SHALL, with reset=1 at a rising edge, set state=IDLE, q=0, r=0, busy=0, done=0, dbz=0, counter=0.
REQ-026 SHALL let reset take priority over start and abort any operation in progress, with no done pulse for the aborted operation.
REQ-027 SHALL accept start on the first edge after reset deasserts.

Verification
REQ-028 SHALL verify basic division: a=100, b=7, start for 1 cycle -> done 17 cycles later; q=14, r=2, dbz=0.
REQ-029 SHALL verify the multiplier round-trip: a=65025, b=255 -> q=255, r=0; and a=65535, b=1 -> q=65535, r=0.
REQ-030 SHALL verify divide-by-zero: a=0x1234, b=0 -> done on the 2nd edge; q=0xFFFF, r=0x34, dbz=1; the next valid divide clears dbz.
REQ-031 SHALL verify start-while-busy: start a=50, b=5, then pulse start with a=9, b=3 at cycle 5 -> single done with q=10, r=0; busy high throughout.
REQ-032 SHALL verify reset mid-operation: assert reset at cycle 8 of RUN -> next cycle busy=0, q=0, r=0, no done; a new start (a=9, b=2) gives q=4, r=1.
REQ-033 SHALL verify back-to-back: start at the cycle after done -> second done exactly 17 cycles later, with correct results for both operations.
